// File: rtl/sd_cmd_scheduler.sv
// Round-robin owner of the SD CMD line: two requesters, transmitter handshake, NCR timeout, retry.
// Optional build macro SD_CMD_SCHED_STATS_EN adds saturating retry/timeout statistics outputs.
module sd_cmd_scheduler #(
    parameter int NCR_MAX   = 64,
    parameter int NRC_GAP   = 8,
    parameter int MAX_RETRY = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  req,
    input  logic [11:0] req_cmd_id,
    input  logic [63:0] req_arg,
    input  logic [1:0]  req_rsp,
    output logic [1:0]  done,
    output logic [1:0]  err,
    output logic        busy,
    output logic        snd_en,
    output logic [5:0]  snd_cmd_id,
    output logic [7:0]  snd_arg1,
    output logic [7:0]  snd_arg2,
    output logic [7:0]  snd_arg3,
    output logic [7:0]  snd_arg4,
    input  logic        snd_done,
    output logic        rsp_en,
    input  logic        rsp_done,
    input  logic        rsp_crc_err
`ifdef SD_CMD_SCHED_STATS_EN
    ,
    output logic [15:0] stat_retries,
    output logic [15:0] stat_timeouts
`endif
);

    localparam int NCR_W   = $clog2(NCR_MAX) + 1;
    localparam int GAP_W   = $clog2(NRC_GAP + 1);
    localparam int RETRY_W = $clog2(MAX_RETRY + 1) + 1;

    localparam logic [NCR_W-1:0]   NCR_LAST  = NCR_W'(NCR_MAX - 1);
    localparam logic [GAP_W-1:0]   GAP_LAST  = GAP_W'(NRC_GAP - 1);
    localparam logic [RETRY_W-1:0] RETRY_LIM = RETRY_W'(MAX_RETRY);

    typedef enum logic [2:0] {
        IDLE,
        SEND,
        RELEASE,
        WAIT_RSP,
        GAP,
        FINISH
    } state_t;

    state_t             state;
    logic               grant;
    logic               rr_last;
    logic               rsp_l;
    logic               status_ok;
    logic [RETRY_W-1:0] attempt;
    logic [NCR_W-1:0]   ncr_cnt;
    logic [GAP_W-1:0]   gap_cnt;

    logic               pick;
    logic [5:0]         pick_id;
    logic [31:0]        pick_arg;

    // On a tie the requester that did not finish last wins.
    always_comb begin
        pick = 1'b0;
        if (req == 2'b11) pick = ~rr_last;
        else              pick = req[1];
        pick_id  = pick ? req_cmd_id[11:6] : req_cmd_id[5:0];
        pick_arg = pick ? req_arg[63:32]   : req_arg[31:0];
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            grant      <= 1'b0;
            rr_last    <= 1'b1;
            rsp_l      <= 1'b0;
            status_ok  <= 1'b0;
            attempt    <= '0;
            ncr_cnt    <= '0;
            gap_cnt    <= '0;
            done       <= 2'b00;
            err        <= 2'b00;
            snd_en     <= 1'b0;
            rsp_en     <= 1'b0;
            snd_cmd_id <= 6'd0;
            snd_arg1   <= 8'd0;
            snd_arg2   <= 8'd0;
            snd_arg3   <= 8'd0;
            snd_arg4   <= 8'd0;
`ifdef SD_CMD_SCHED_STATS_EN
            stat_retries  <= 16'd0;
            stat_timeouts <= 16'd0;
`endif
        end else begin
            done <= 2'b00;
            err  <= 2'b00;
            case (state)
                IDLE: begin
                    if (req != 2'b00) begin
                        grant      <= pick;
                        snd_cmd_id <= pick_id;
                        snd_arg1   <= pick_arg[31:24];
                        snd_arg2   <= pick_arg[23:16];
                        snd_arg3   <= pick_arg[15:8];
                        snd_arg4   <= pick_arg[7:0];
                        rsp_l      <= pick ? req_rsp[1] : req_rsp[0];
                        attempt    <= '0;
                        snd_en     <= 1'b1;
                        state      <= SEND;
                    end
                end
                SEND: begin
                    if (snd_done) begin
                        snd_en <= 1'b0;
                        rsp_en <= rsp_l;
                        state  <= RELEASE;
                    end
                end
                RELEASE: begin
                    if (!snd_done) begin
                        if (rsp_l) begin
                            ncr_cnt <= '0;
                            state   <= WAIT_RSP;
                        end else begin
                            status_ok <= 1'b1;
                            gap_cnt   <= '0;
                            state     <= GAP;
                        end
                    end
                end
                WAIT_RSP: begin
                    // A response landing on the timeout clock still counts.
                    if (rsp_done) begin
                        status_ok <= ~rsp_crc_err;
                        rsp_en    <= 1'b0;
                        gap_cnt   <= '0;
                        state     <= GAP;
                    end else if (ncr_cnt == NCR_LAST) begin
                        status_ok <= 1'b0;
                        rsp_en    <= 1'b0;
                        gap_cnt   <= '0;
                        state     <= GAP;
`ifdef SD_CMD_SCHED_STATS_EN
                        if (stat_timeouts != 16'hFFFF) stat_timeouts <= stat_timeouts + 16'd1;
`endif
                    end else if (ncr_cnt != '1) begin
                        ncr_cnt <= ncr_cnt + 1'b1;
                    end
                end
                GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        gap_cnt <= '0;
                        if (status_ok) begin
                            done  <= grant ? 2'b10 : 2'b01;
                            state <= FINISH;
                        end else if (attempt < RETRY_LIM) begin
                            attempt <= attempt + 1'b1;
                            snd_en  <= 1'b1;
                            state   <= SEND;
`ifdef SD_CMD_SCHED_STATS_EN
                            if (stat_retries != 16'hFFFF) stat_retries <= stat_retries + 16'd1;
`endif
                        end else begin
                            done  <= grant ? 2'b10 : 2'b01;
                            err   <= grant ? 2'b10 : 2'b01;
                            state <= FINISH;
                        end
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                FINISH: begin
                    rr_last <= grant;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sd_cmd_scheduler.sv
// Directed bench for sd_cmd_scheduler; the bench plays both requesters, the transmitter and the receiver.
module tb_sd_cmd_scheduler;

    localparam int NCR_MAX   = 64;
    localparam int NRC_GAP   = 8;
    localparam int MAX_RETRY = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req;
    logic [11:0] req_cmd_id;
    logic [63:0] req_arg;
    logic [1:0]  req_rsp;
    logic [1:0]  done;
    logic [1:0]  err;
    logic        busy;
    logic        snd_en;
    logic [5:0]  snd_cmd_id;
    logic [7:0]  snd_arg1, snd_arg2, snd_arg3, snd_arg4;
    logic        snd_done;
    logic        rsp_en;
    logic        rsp_done;
    logic        rsp_crc_err;
`ifdef SD_CMD_SCHED_STATS_EN
    logic [15:0] stat_retries;
    logic [15:0] stat_timeouts;
`endif

    sd_cmd_scheduler #(
        .NCR_MAX   (NCR_MAX),
        .NRC_GAP   (NRC_GAP),
        .MAX_RETRY (MAX_RETRY)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .req_cmd_id  (req_cmd_id),
        .req_arg     (req_arg),
        .req_rsp     (req_rsp),
        .done        (done),
        .err         (err),
        .busy        (busy),
        .snd_en      (snd_en),
        .snd_cmd_id  (snd_cmd_id),
        .snd_arg1    (snd_arg1),
        .snd_arg2    (snd_arg2),
        .snd_arg3    (snd_arg3),
        .snd_arg4    (snd_arg4),
        .snd_done    (snd_done),
        .rsp_en      (rsp_en),
        .rsp_done    (rsp_done),
        .rsp_crc_err (rsp_crc_err)
`ifdef SD_CMD_SCHED_STATS_EN
        ,
        .stat_retries  (stat_retries),
        .stat_timeouts (stat_timeouts)
`endif
    );

    always #5 clk = ~clk;

    int   n_cmp = 0;
    int   n_fail = 0;
    int   snd_rises = 0;
    int   rsp_en_cycles = 0;
    int   last_wait = 0;
    logic prev_snd_en = 1'b0;
    logic done_seen = 1'b0;

    // One clock; outputs are observed 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
        if (snd_en && !prev_snd_en) snd_rises++;
        prev_snd_en = snd_en;
        if (rsp_en) rsp_en_cycles++;
        if (done != 2'b00) done_seen = 1'b1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_snd_en(input string tag);
        int k = 0;
        while (!snd_en && k < 300) begin
            tick();
            k++;
        end
        check({tag, "_snd_en_seen"}, 64'(snd_en), 64'd1);
    endtask

    // Transmitter: raise Complite lat clocks after Enable, drop it once Enable falls.
    task automatic finish_send(input string tag, input int lat);
        int k = 0;
        repeat (lat) tick();
        snd_done = 1'b1;
        tick();
        while (snd_en && k < 300) begin
            tick();
            k++;
        end
        snd_done = 1'b0;
        check({tag, "_snd_en_dropped"}, 64'(snd_en), 64'd0);
    endtask

    task automatic wait_done(input string tag);
        int k = 0;
        while (done == 2'b00 && k < 2000) begin
            tick();
            k++;
        end
        last_wait = k;
        check({tag, "_done_seen"}, 64'(done != 2'b00), 64'd1);
    endtask

    task automatic end_txn(input string tag);
        req = 2'b00;
        tick();
        check({tag, "_done_cleared"}, 64'(done), 64'd0);
        check({tag, "_busy_cleared"}, 64'(busy), 64'd0);
    endtask

    initial begin
        rst = 1'b1;
        req = 2'b00;
        req_cmd_id = 12'd0;
        req_arg = 64'd0;
        req_rsp = 2'b00;
        snd_done = 1'b0;
        rsp_done = 1'b0;
        rsp_crc_err = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        tick();

        check("rst_snd_en", 64'(snd_en), 64'd0);
        check("rst_rsp_en", 64'(rsp_en), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_cmd_id", 64'(snd_cmd_id), 64'd0);
        check("rst_args", 64'({snd_arg1, snd_arg2, snd_arg3, snd_arg4}), 64'd0);

        // Fire-and-forget CMD0 from requester 0.
        rsp_en_cycles = 0;
        req = 2'b01;
        req_cmd_id = 12'd0;
        req_arg = 64'd0;
        req_rsp = 2'b00;
        wait_snd_en("t1");
        check("t1_cmd_id", 64'(snd_cmd_id), 64'd0);
        check("t1_busy", 64'(busy), 64'd1);
        finish_send("t1", 48);
        wait_done("t1");
        // Counted from the edge at which snd_done was dropped: done shows in cycle NRC_GAP+2.
        check("t1_done_latency", 64'(last_wait), 64'(NRC_GAP + 1));
        check("t1_done", 64'(done), 64'h1);
        check("t1_err", 64'(err), 64'h0);
        check("t1_rsp_en_never", 64'(rsp_en_cycles), 64'd0);
        end_txn("t1");

        // CMD17 from requester 1 with a clean response.
        snd_rises = 0;
        req = 2'b10;
        req_cmd_id = {6'd17, 6'd0};
        req_arg = {32'h0000_0200, 32'h0};
        req_rsp = 2'b10;
        wait_snd_en("t2");
        check("t2_cmd_id", 64'(snd_cmd_id), 64'd17);
        check("t2_args", 64'({snd_arg1, snd_arg2, snd_arg3, snd_arg4}), 64'h0000_0200);
        finish_send("t2", 3);
        check("t2_rsp_en", 64'(rsp_en), 64'd1);
        tick();
        repeat (20) tick();
        rsp_done = 1'b1;
        tick();
        rsp_done = 1'b0;
        check("t2_rsp_en_off", 64'(rsp_en), 64'd0);
        wait_done("t2");
        check("t2_done", 64'(done), 64'h2);
        check("t2_err", 64'(err), 64'h0);
        check("t2_attempts", 64'(snd_rises), 64'd1);
        end_txn("t2");

        // Both requesters together, twice: grants alternate 0,1,0,1.
        req_cmd_id = {6'd9, 6'd5};
        req_arg = {32'h1111_2222, 32'h3333_4444};
        req_rsp = 2'b00;
        req = 2'b11;
        for (int r = 0; r < 4; r++) begin
            wait_snd_en("rr");
            check($sformatf("rr%0d_cmd_id", r), 64'(snd_cmd_id), (r % 2 == 0) ? 64'd5 : 64'd9);
            finish_send("rr", 2);
            wait_done("rr");
            check($sformatf("rr%0d_done", r), 64'(done), (r % 2 == 0) ? 64'h1 : 64'h2);
            if (r == 0) req = 2'b10;
            else if (r == 1) req = 2'b11;
            else if (r == 2) req = 2'b10;
            else req = 2'b00;
            tick();
        end
        tick();
        check("rr_idle_busy", 64'(busy), 64'd0);

        // No response ever: four attempts, each WAIT_RSP lasting NCR_MAX clocks.
        snd_rises = 0;
        rsp_en_cycles = 0;
        req = 2'b01;
        req_cmd_id = {6'd0, 6'd13};
        req_arg = 64'd0;
        req_rsp = 2'b01;
        for (int a = 0; a <= MAX_RETRY; a++) begin
            wait_snd_en("to");
            finish_send("to", 2);
        end
        wait_done("to");
        check("to_done", 64'(done), 64'h1);
        check("to_err", 64'(err), 64'h1);
        check("to_attempts", 64'(snd_rises), 64'(MAX_RETRY + 1));
        check("to_rsp_en_cycles", 64'(rsp_en_cycles), 64'((MAX_RETRY + 1) * (NCR_MAX + 1)));
`ifdef SD_CMD_SCHED_STATS_EN
        check("to_stat_timeouts", 64'(stat_timeouts), 64'd4);
        check("to_stat_retries", 64'(stat_retries), 64'd3);
`endif
        end_txn("to");

        // Reset while waiting for the response.
        req = 2'b01;
        req_cmd_id = {6'd0, 6'd8};
        req_rsp = 2'b01;
        wait_snd_en("rs");
        finish_send("rs", 2);
        tick();
        repeat (5) tick();
        check("rs_rsp_en_armed", 64'(rsp_en), 64'd1);
        rst = 1'b1;
        req = 2'b00;
        done_seen = 1'b0;
        tick();
        check("rs_snd_en", 64'(snd_en), 64'd0);
        check("rs_rsp_en", 64'(rsp_en), 64'd0);
        check("rs_busy", 64'(busy), 64'd0);
        check("rs_done", 64'(done), 64'd0);
        rst = 1'b0;
        repeat (NCR_MAX + NRC_GAP + 4) tick();
        check("rs_no_done", 64'(done_seen), 64'd0);
`ifdef SD_CMD_SCHED_STATS_EN
        check("rs_stat_timeouts", 64'(stat_timeouts), 64'd0);
        check("rs_stat_retries", 64'(stat_retries), 64'd0);
`endif

        // CRC error on the first response, clean on the retry.
        snd_rises = 0;
        req = 2'b01;
        req_cmd_id = {6'd0, 6'd55};
        req_arg = {32'h0, 32'hDEAD_BEEF};
        req_rsp = 2'b01;
        wait_snd_en("crc");
        finish_send("crc", 2);
        tick();
        repeat (3) tick();
        rsp_done = 1'b1;
        rsp_crc_err = 1'b1;
        tick();
        rsp_done = 1'b0;
        rsp_crc_err = 1'b0;
        req_arg = 64'd0;
        wait_snd_en("crc_retry");
        check("crc_retry_cmd_id", 64'(snd_cmd_id), 64'd55);
        check("crc_retry_args", 64'({snd_arg1, snd_arg2, snd_arg3, snd_arg4}), 64'hDEAD_BEEF);
        finish_send("crc_retry", 2);
        tick();
        repeat (4) tick();
        rsp_done = 1'b1;
        tick();
        rsp_done = 1'b0;
        wait_done("crc");
        check("crc_done", 64'(done), 64'h1);
        check("crc_err", 64'(err), 64'h0);
        check("crc_attempts", 64'(snd_rises), 64'd2);
`ifdef SD_CMD_SCHED_STATS_EN
        check("crc_stat_retries", 64'(stat_retries), 64'd1);
        check("crc_stat_timeouts", 64'(stat_timeouts), 64'd0);
`endif
        end_txn("crc");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/sd_cmd_scheduler.md
Name: sd_cmd_scheduler

Overview:
Shares the single SD CMD-line transmitter and response receiver between two requesters: requester 0 is the card-init FSM and requester 1 is the block read/write FSM. It arbitrates round-robin and runs the transmitter Enable/Complite handshake. It then waits for the card response with an NCR timeout and retries failed commands. Each requester sees a simple req/done/err interface; only the scheduler touches the CMD path.

Parameters:
NCR_MAX, 64, clocks to wait for response completion after the command is sent before declaring timeout.
NRC_GAP, 8, idle clocks inserted between end of response/timeout and the next command or retry.
MAX_RETRY, 3, number of retries after the first attempt (so up to MAX_RETRY+1 attempts).

Ports:
clk  in  1  SD clock; all logic on posedge.
rst  in  1  reset, synchronous, active-high.
req  in  2  per-requester request level; held until the matching done pulse.
req_cmd_id  in  12  {req1 id, req0 id}, 6 bits each.
req_arg  in  64  {req1 arg, req0 arg}, 32 bits each, arg[31:24] sent first.
req_rsp  in  2  1 = command expects a response; 0 = fire-and-forget (e.g. CMD0).
done  out  2  one-clock pulse per requester on completion, success or failure.
err  out  2  valid with done; 1 = all attempts failed.
busy  out  1  high in any state except IDLE.
snd_en  out  1  transmitter Enable.
snd_cmd_id  out  6  to transmitter.
snd_arg1..snd_arg4  out  8 each  to transmitter; arg1 = arg[31:24] … arg4 = arg[7:0].
snd_done  in  1  transmitter Complite.
rsp_en  out  1  arms the response receiver.
rsp_done  in  1  one-clock pulse: response fully received.
rsp_crc_err  in  1  qualifies rsp_done; 1 = CRC/end-bit error.

Behaviour:
- Reset values: snd_en=0, rsp_en=0, done=0, err=0, busy=0, snd_cmd_id=0, snd_arg*=0, rr_last=1 (requester 0 wins the first tie). Counters are cleared and state is IDLE.
- A reset mid-transaction immediately drops snd_en and rsp_en. No done pulse is issued. The requester must re-request.
- States: IDLE, SEND, RELEASE, WAIT_RSP, GAP, FINISH.
- IDLE: if any req is set, grant it. If both are set, grant the one that is not rr_last. Latch the grant, cmd_id and arg into output registers. Set attempt=0. Go to SEND. The latched values stay stable until FINISH, even if req inputs change.
- SEND: snd_en=1 until snd_done=1.
  - On snd_done: snd_en<=0 and go to RELEASE.
  - If req_rsp of the grant is set, also set rsp_en<=1 in the same clock.
- RELEASE: wait for snd_done=0, i.e. the transmitter has returned to idle.
  - If a response is expected, go to WAIT_RSP and clear the timeout counter.
  - Otherwise go to GAP with status=OK.
- WAIT_RSP: the counter increments each clock.
  - rsp_done with rsp_crc_err=0: status=OK, go to GAP.
  - rsp_done with rsp_crc_err=1: status=FAIL, go to GAP.
  - Counter reaches NCR_MAX-1 with no rsp_done: status=FAIL, go to GAP.
  - If rsp_done and the timeout fall on the same clock, rsp_done wins.
  - rsp_en<=0 on leaving this state.
- GAP: count NRC_GAP clocks, then:
  - status=OK: go to FINISH with err=0.
  - status=FAIL and attempt<MAX_RETRY: attempt++, go to SEND with the same latched command.
  - otherwise: go to FINISH with err=1.
- FINISH: pulse done[grant] for one clock with err[grant]. Set rr_last=grant. Go to IDLE.
- The requester must drop req on the clock after done. A req still high in the next IDLE is treated as a new request.
- rsp_done arriving outside WAIT_RSP is ignored.
- The timeout counter is $clog2(NCR_MAX)+1 bits and saturates; it does not wrap.

Optional Feature:
SD_CMD_SCHED_STATS_EN
- Defined: adds outputs stat_retries[15:0] and stat_timeouts[15:0].
  - stat_retries increments on every GAP->SEND retry.
  - stat_timeouts increments on every WAIT_RSP timeout.
  - Both saturate at 16'hFFFF and clear only on rst.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- req=01, cmd_id0=0, arg0=0, rsp=0; snd_done asserts 48 clocks after snd_en → snd_cmd_id=0, rsp_en never high, done=01 with err=00 exactly NRC_GAP+2 clocks after snd_done falls.
- req=10, cmd_id1=17, arg1=32'h0000_0200, rsp=1; rsp_done pulses 20 clocks into WAIT_RSP with crc_err=0 → snd_arg1..4=00,00,02,00, done=10, err=00, one attempt.
- req=11 asserted together, twice back-to-back → grant order is 0, then 1, then 0, then 1; snd_cmd_id follows the latched ids.
- rsp=1 and rsp_done never arrives → 4 SEND phases, each WAIT_RSP lasts 64 clocks, then done with err=1. With the stats macro defined, stat_timeouts=4 and stat_retries=3.
- First response has crc_err=1, second attempt is OK → exactly 2 snd_en assertions, err=0, stat_retries=1.
- rst asserted during WAIT_RSP → next clock snd_en=0, rsp_en=0, busy=0, no done; a subsequent req completes normally.
